// File: rtl/posit_add_pipe.sv
// posit_add_pkg: width helpers shared by the adder and anything that instantiates it.
// NORMAL gives the decoded-operand widths; AADD gives the widths of an unrounded sum.
package posit_add_pkg;
    typedef enum logic {NORMAL, AADD} width_mode_e;

    function automatic int get_scale_width(input int n, input int es, input width_mode_e mode);
        int w;
        // Largest |scale| of an n-bit posit is (n-2) * 2^es; one extra bit for the sign.
        w = $clog2(((n - 2) << es) + 1) + 1;
        // A sum can carry one scale up or cancel many down; one more bit covers both.
        if (mode == AADD) w = w + 1;
        return w;
    endfunction

    function automatic int get_fraction_width(input int n, input int es, input width_mode_e mode);
        int w;
        // Sign, a two-bit minimum regime and the exponent field leave the rest for fraction.
        w = n - es - 3;
        if (w < 1) w = 1;
        // An unrounded sum also carries guard, round and sticky.
        if (mode == AADD) w = w + 3;
        return w;
    endfunction
endpackage

// Purpose: posit adder/subtractor on decoded operands; unrounded result with G/R/S and a tag.
// Latency: 3 registered stages (align, add, normalize); one operation per cycle.
// Backpressure: in_ready = ~v3 | out_ready; all stages stall together while it is low.
// Ports: clk/rst_n; in_valid/in_ready, in_sub, in_tag, a_*/b_* decoded operands;
//        out_valid/out_ready, r_nar/r_zero/r_sign/r_scale/r_frac, r_guard/r_round/r_sticky, r_tag.
module posit_add_pipe
    import posit_add_pkg::*;
#(
    parameter int POSIT_WIDTH = 8,
    parameter int POSIT_ES    = 1,
    parameter int TAG_W       = 4,
    localparam int SW  = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL),
    localparam int FW  = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL),
    localparam int SWA = get_scale_width(POSIT_WIDTH, POSIT_ES, AADD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sub,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  a_nar,
    input  logic                  a_zero,
    input  logic                  a_sign,
    input  logic signed [SW-1:0]  a_scale,
    input  logic [FW-1:0]         a_frac,
    input  logic                  b_nar,
    input  logic                  b_zero,
    input  logic                  b_sign,
    input  logic signed [SW-1:0]  b_scale,
    input  logic [FW-1:0]         b_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  r_nar,
    output logic                  r_zero,
    output logic                  r_sign,
    output logic signed [SWA-1:0] r_scale,
    output logic [FW-1:0]         r_frac,
    output logic                  r_guard,
    output logic                  r_round,
    output logic                  r_sticky,
    output logic [TAG_W-1:0]      r_tag
);
    localparam int MW   = FW + 4;          // {hidden, frac, 3 GRS slots}
    localparam int SUMW = FW + 5;          // MW plus carry
    localparam int SHW  = SW + 1;
    localparam int LZW  = $clog2(MW + 1);

    // Stage registers
    logic                 r_s1_vld, r_s1_nar, r_s1_zero, r_s1_sign, r_s1_sub;
    logic signed [SW-1:0] r_s1_scale;
    logic [MW-1:0]        r_s1_lman, r_s1_sman;
    logic [TAG_W-1:0]     r_s1_tag;
    logic                 r_s2_vld, r_s2_nar, r_s2_zero, r_s2_sign;
    logic signed [SW-1:0] r_s2_scale;
    logic [SUMW-1:0]      r_s2_sum;
    logic [TAG_W-1:0]     r_s2_tag;
    logic                 r_s3_vld, r_s3_nar, r_s3_zero, r_s3_sign, r_s3_g, r_s3_r, r_s3_s;
    logic [SWA-1:0]       r_s3_scale;
    logic [FW-1:0]        r_s3_frac;
    logic [TAG_W-1:0]     r_s3_tag;

    logic w_adv;
    assign w_adv     = ~r_s3_vld | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s3_vld;

    // ---------------- S1: compare, swap, sticky-align ----------------
    logic                 w_b_sign_eff, w_a_large, w_l_sign, w_s_sign, w_s_zero;
    logic signed [SW-1:0] w_l_scale, w_s_scale;
    logic [FW-1:0]        w_l_frac, w_s_frac;
    logic [SHW-1:0]       w_sh;
    logic [MW-1:0]        w_s_man, w_mask, w_aligned;

    always_comb begin
        w_b_sign_eff = b_sign ^ in_sub;
        // Zero always loses the comparison; equal magnitudes pick a.
        w_a_large = b_zero | (~a_zero & ((a_scale > b_scale) |
                    ((a_scale == b_scale) & (a_frac >= b_frac))));
        w_l_sign  = w_a_large ? a_sign       : w_b_sign_eff;
        w_s_sign  = w_a_large ? w_b_sign_eff : a_sign;
        w_l_scale = w_a_large ? a_scale : b_scale;
        w_s_scale = w_a_large ? b_scale : a_scale;
        w_l_frac  = w_a_large ? a_frac  : b_frac;
        w_s_frac  = w_a_large ? b_frac  : a_frac;
        w_s_zero  = w_a_large ? b_zero  : a_zero;
        w_sh      = {w_l_scale[SW-1], w_l_scale} - {w_s_scale[SW-1], w_s_scale};
        w_s_man   = {1'b1, w_s_frac, 3'b000};
        w_mask    = ~({MW{1'b1}} << w_sh);
        if (w_s_zero)
            w_aligned = '0;
        else if (w_sh >= SHW'(MW))
            w_aligned = MW'(1);            // everything shifted out: sticky only
        else
            w_aligned = (w_s_man >> w_sh) | MW'(|(w_s_man & w_mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_scale <= '0;
            r_s1_lman  <= '0;
            r_s1_sman  <= '0;
            r_s1_tag   <= '0;
        end else if (w_adv) begin
            r_s1_vld   <= in_valid;
            r_s1_nar   <= a_nar | b_nar;
            r_s1_zero  <= a_zero & b_zero;
            r_s1_sign  <= w_l_sign;
            r_s1_sub   <= w_l_sign ^ w_s_sign;
            r_s1_scale <= w_l_scale;
            r_s1_lman  <= {1'b1, w_l_frac, 3'b000};
            r_s1_sman  <= w_aligned;
            r_s1_tag   <= in_tag;
        end
    end

    // ---------------- S2: add / subtract (large minus small never borrows) ----------------
    logic [SUMW-1:0] w_sum;
    always_comb begin
        if (r_s1_sub) w_sum = {1'b0, r_s1_lman} - {1'b0, r_s1_sman};
        else          w_sum = {1'b0, r_s1_lman} + {1'b0, r_s1_sman};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld   <= 1'b0;
            r_s2_nar   <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_scale <= '0;
            r_s2_sum   <= '0;
            r_s2_tag   <= '0;
        end else if (w_adv) begin
            r_s2_vld   <= r_s1_vld;
            r_s2_nar   <= r_s1_nar;
            r_s2_zero  <= r_s1_zero;
            r_s2_sign  <= r_s1_sign;
            r_s2_scale <= r_s1_scale;
            r_s2_sum   <= w_sum;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // ---------------- S3: leading-one normalize ----------------
    logic           w_carry, w_res_zero, w_live;
    logic [LZW-1:0] w_lz;
    logic [MW-1:0]  w_norm;           // leading one lands in the top bit
    logic [SWA-1:0] w_scale_ext, w_n_scale;

    always_comb begin
        w_carry = r_s2_sum[SUMW-1];
        w_lz    = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (r_s2_sum[i]) w_lz = LZW'(MW - 1 - i);
        w_scale_ext = {{(SWA-SW){r_s2_scale[SW-1]}}, r_s2_scale};
        if (w_carry) begin
            w_norm    = r_s2_sum[MW:1];
            w_norm[0] = r_s2_sum[1] | r_s2_sum[0];
            w_n_scale = w_scale_ext + SWA'(1);
        end else begin
            w_norm    = r_s2_sum[MW-1:0] << w_lz;
            w_n_scale = w_scale_ext - SWA'(w_lz);
        end
        // A non-zero sum always normalizes to a set top bit.
        w_res_zero = r_s2_zero | ~w_norm[MW-1];
        w_live     = ~r_s2_nar & ~w_res_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld   <= 1'b0;
            r_s3_nar   <= 1'b0;
            r_s3_zero  <= 1'b0;
            r_s3_sign  <= 1'b0;
            r_s3_scale <= '0;
            r_s3_frac  <= '0;
            r_s3_g     <= 1'b0;
            r_s3_r     <= 1'b0;
            r_s3_s     <= 1'b0;
            r_s3_tag   <= '0;
        end else if (w_adv) begin
            // NaR and zero results clear the numeric fields so they stay deterministic.
            r_s3_vld   <= r_s2_vld;
            r_s3_nar   <= r_s2_nar;
            r_s3_zero  <= ~r_s2_nar & w_res_zero;
            r_s3_sign  <= w_live & r_s2_sign;
            r_s3_scale <= w_live ? w_n_scale : '0;
            r_s3_frac  <= w_live ? w_norm[MW-2:3] : '0;
            r_s3_g     <= w_live & w_norm[2];
            r_s3_r     <= w_live & w_norm[1];
            r_s3_s     <= w_live & w_norm[0];
            r_s3_tag   <= r_s2_tag;
        end
    end

    assign r_nar    = r_s3_nar;
    assign r_zero   = r_s3_zero;
    assign r_sign   = r_s3_sign;
    assign r_scale  = r_s3_scale;
    assign r_frac   = r_s3_frac;
    assign r_guard  = r_s3_g;
    assign r_round  = r_s3_r;
    assign r_sticky = r_s3_s;
    assign r_tag    = r_s3_tag;
endmodule
